vscale_commit_trace: RTL

Hardware commit-trace collector that sits directly downstream of the vscale pipeline writeback stages. It shadows the DX→WB→FWB instruction flow, builds one record per retired integer instruction, retired FP-writeback instruction and exception, and buffers the records in an in-order FIFO. The FIFO drains through a valid/ready port to a trace sink, such as a memory-mapped dump or a simulation logger.

---
 rtl/vscale_commit_trace.sv | 110 +++++++++++
 1 files changed

// File: rtl/vscale_commit_trace.sv
// vscale_commit_trace: shadows vscale DX/WB/FWB retirement and buffers one record
// per retired instruction or exception in an in-order FIFO drained via valid/ready.
module vscale_commit_trace #(
    parameter int DEPTH       = 16,
    parameter int CNT_W       = 16,
    parameter int ECODE_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   trace_en,
    input  logic [63:0]            cycle,
    input  logic                   stall_DX,
    input  logic [31:0]            PC_DX,
    input  logic [31:0]            inst_DX,
    input  logic                   stall_WB,
    input  logic                   retire_WB,
    input  logic                   wr_reg_WB,
    input  logic [4:0]             reg_to_wr_WB,
    input  logic [31:0]            wb_data_WB,
    input  logic                   wr_freg_WB,
    input  logic                   wr_freg_FWB,
    input  logic [4:0]             freg_to_wr_FWB,
    input  logic [31:0]            wb_data_FWB,
    input  logic                   exception_WB,
    input  logic [ECODE_WIDTH-1:0] exception_code_WB,
    output logic                   rec_valid,
    input  logic                   rec_ready,
    output logic [1:0]             rec_kind,
    output logic [63:0]            rec_cycle,
    output logic [31:0]            rec_pc,
    output logic [31:0]            rec_inst,
    output logic [4:0]             rec_rd,
    output logic                   rec_wen,
    output logic [31:0]            rec_data,
    output logic [CNT_W-1:0]       drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    typedef struct packed {
        logic [1:0]  kind;
        logic [63:0] cyc;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] data;
    } rec_t;
    logic [31:0]      pc_wb_q, inst_wb_q, pc_fwb_q, inst_fwb_q;
    logic             fwb_pend_q;
    rec_t             mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W:0]   drop_sum;
    logic             f_v, s_v, f_push, s_push, pop;
    rec_t             f_rec, s_rec, head;
    // F is older than I/E, so it claims a free slot first; capacity uses start-of-cycle count
    always_comb begin
        f_v      = trace_en & fwb_pend_q;
        s_v      = trace_en & ((retire_WB & ~wr_freg_WB) | exception_WB);
        f_rec    = {2'd1, cycle, pc_fwb_q, inst_fwb_q, freg_to_wr_FWB, wr_freg_FWB, wb_data_FWB};
        s_rec    = exception_WB ? {2'd2, cycle, pc_wb_q, inst_wb_q, 5'd0, 1'b0, 32'(exception_code_WB)}
                                : {2'd0, cycle, pc_wb_q, inst_wb_q, reg_to_wr_WB,
                                   wr_reg_WB & (reg_to_wr_WB != 5'd0), wb_data_WB};
        f_push   = f_v & (count_q < FULL);
        s_push   = s_v & ((count_q + (AW+1)'(f_push)) < FULL);
        pop      = (count_q != '0) & rec_ready;
        wptr_d   = wptr_q + AW'(f_push) + AW'(s_push);
        rptr_d   = rptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(f_push) + (AW+1)'(s_push) - (AW+1)'(pop);
        drop_sum = {1'b0, drop_q} + (CNT_W+1)'(f_v & ~f_push) + (CNT_W+1)'(s_v & ~s_push);
        drop_d   = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        head     = (count_q != '0) ? mem_q[rptr_q] : '0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_wb_q    <= '0;
            inst_wb_q  <= '0;
            pc_fwb_q   <= '0;
            inst_fwb_q <= '0;
            fwb_pend_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            drop_q     <= '0;
        end else begin
            if (!stall_DX) begin
                pc_wb_q   <= PC_DX;
                inst_wb_q <= inst_DX;
            end
            if (!stall_WB) begin
                pc_fwb_q   <= pc_wb_q;
                inst_fwb_q <= inst_wb_q;
            end
            fwb_pend_q <= ~stall_WB & retire_WB & wr_freg_WB;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
        end
    end
    // storage needs no reset: the head is masked whenever the FIFO is empty
    always_ff @(posedge clk) begin
        if (f_push) mem_q[wptr_q] <= f_rec;
        if (s_push) mem_q[wptr_q + AW'(f_push)] <= s_rec;
    end
    assign rec_valid = count_q != '0;
    assign {rec_kind, rec_cycle, rec_pc, rec_inst, rec_rd, rec_wen, rec_data} = head;
    assign drop_cnt  = drop_q;
endmodule
